// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - handshake and result bundle between the card datapath and frame_sequencer
interface frame_sequencer_if;
  logic        frame_start_in;
  logic        com_valid_in;
  logic [10:0] x_com_in;
  logic [9:0]  y_com_in;
  logic        edges_valid_in;
  logic [10:0] left_in;
  logic [10:0] right_in;
  logic [9:0]  top_in;
  logic [9:0]  bot_in;
  logic [5:0]  card_map_in;
  logic [6:0]  rank_score_in;
  logic [6:0]  suit_score_in;

  logic        find_corners_out;
  logic [10:0] x_com_out;
  logic [9:0]  y_com_out;
  logic [10:0] left_out;
  logic [10:0] right_out;
  logic [9:0]  top_out;
  logic [9:0]  bot_out;
  logic        classify_en_out;
  logic [5:0]  card_map_out;
  logic [6:0]  rank_score_out;
  logic [6:0]  suit_score_out;
  logic        result_valid_out;
  logic [7:0]  timeout_count_out;
  logic [7:0]  reject_count_out;
  logic [1:0]  state_out;

  modport master (
    output frame_start_in, com_valid_in, x_com_in, y_com_in, edges_valid_in,
           left_in, right_in, top_in, bot_in, card_map_in, rank_score_in, suit_score_in,
    input  find_corners_out, x_com_out, y_com_out, left_out, right_out, top_out, bot_out,
           classify_en_out, card_map_out, rank_score_out, suit_score_out, result_valid_out,
           timeout_count_out, reject_count_out, state_out
  );

  modport slave (
    input  frame_start_in, com_valid_in, x_com_in, y_com_in, edges_valid_in,
           left_in, right_in, top_in, bot_in, card_map_in, rank_score_in, suit_score_in,
    output find_corners_out, x_com_out, y_com_out, left_out, right_out, top_out, bot_out,
           classify_en_out, card_map_out, rank_score_out, suit_score_out, result_valid_out,
           timeout_count_out, reject_count_out, state_out
  );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame COM -> edges -> one-frame classify -> publish controller
// Optional RESULT_HOLD_EN: publish only when two consecutive classifications agree.
module frame_sequencer #(
  parameter int EDGE_TIMEOUT = 65536,
  parameter int MIN_SPAN     = 16
) (
  input logic             clk_in,
  input logic             rst_in,
  frame_sequencer_if.slave bus
);

  localparam int TW = (EDGE_TIMEOUT > 2) ? $clog2(EDGE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(EDGE_TIMEOUT - 1);

  localparam logic [1:0] WAIT_COM   = 2'd0;
  localparam logic [1:0] FIND_EDGES = 2'd1;
  localparam logic [1:0] ARM        = 2'd2;
  localparam logic [1:0] CLASSIFY   = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          geom_ok;
  logic          publish;

  // Widened by one bit so left+MIN_SPAN near full scale cannot wrap into an accept.
  always_comb begin
    geom_ok = ({1'b0, bus.right_in} >= ({1'b0, bus.left_in} + 12'(MIN_SPAN))) &&
              ({1'b0, bus.bot_in}   >= ({1'b0, bus.top_in}  + 11'(MIN_SPAN)));
  end

`ifdef RESULT_HOLD_EN
  logic [5:0] prev_card;

  always_comb publish = (bus.card_map_in == prev_card);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_card <= 6'h3F;
    end else if (state == CLASSIFY && bus.frame_start_in) begin
      prev_card <= bus.card_map_in;
    end
  end
`else
  always_comb publish = 1'b1;
`endif

  assign bus.state_out = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                 <= WAIT_COM;
      timer                 <= '0;
      bus.find_corners_out  <= 1'b0;
      bus.x_com_out         <= '0;
      bus.y_com_out         <= '0;
      bus.left_out          <= '0;
      bus.right_out         <= '0;
      bus.top_out           <= '0;
      bus.bot_out           <= '0;
      bus.classify_en_out   <= 1'b0;
      bus.card_map_out      <= '0;
      bus.rank_score_out    <= '0;
      bus.suit_score_out    <= '0;
      bus.result_valid_out  <= 1'b0;
      bus.timeout_count_out <= '0;
      bus.reject_count_out  <= '0;
    end else begin
      bus.find_corners_out <= 1'b0;
      bus.result_valid_out <= 1'b0;
      case (state)
        WAIT_COM: begin
          if (bus.com_valid_in) begin
            bus.x_com_out        <= bus.x_com_in;
            bus.y_com_out        <= bus.y_com_in;
            bus.find_corners_out <= 1'b1;
            timer                <= '0;
            state                <= FIND_EDGES;
          end
        end
        FIND_EDGES: begin
          timer <= timer + 1'b1;
          if (bus.edges_valid_in) begin
            if (geom_ok) begin
              bus.left_out  <= bus.left_in;
              bus.right_out <= bus.right_in;
              bus.top_out   <= bus.top_in;
              bus.bot_out   <= bus.bot_in;
              state         <= ARM;
            end else begin
              if (bus.reject_count_out != 8'hFF) bus.reject_count_out <= bus.reject_count_out + 1'b1;
              state <= WAIT_COM;
            end
          end else if (timer == TIMER_LAST) begin
            if (bus.timeout_count_out != 8'hFF) bus.timeout_count_out <= bus.timeout_count_out + 1'b1;
            state <= WAIT_COM;
          end
        end
        ARM: begin
          if (bus.frame_start_in) begin
            bus.classify_en_out <= 1'b1;
            state               <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (bus.frame_start_in) begin
            if (publish) begin
              bus.card_map_out     <= bus.card_map_in;
              bus.rank_score_out   <= bus.rank_score_in;
              bus.suit_score_out   <= bus.suit_score_in;
              bus.result_valid_out <= 1'b1;
            end
            bus.classify_en_out <= 1'b0;
            state               <= WAIT_COM;
          end
        end
        default: state <= WAIT_COM;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed plus randomized check of frame_sequencer against a transaction-level model
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_sequencer_if bus();

  frame_sequencer #(.EDGE_TIMEOUT(32), .MIN_SPAN(16)) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_xc, m_yc, m_l, m_r, m_t, m_b, m_card, m_rs, m_ss, m_tc, m_rc, m_state, m_ce, m_prev;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_xc = 0; m_yc = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0;
    m_card = 0; m_rs = 0; m_ss = 0; m_tc = 0; m_rc = 0;
    m_state = 0; m_ce = 0; m_prev = 63;
  endtask

  task automatic idle_inputs();
    bus.frame_start_in = 1'b0;
    bus.com_valid_in   = 1'b0;
    bus.edges_valid_in = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".x_com"},   32'(bus.x_com_out),         32'(m_xc));
    chk({tag, ".y_com"},   32'(bus.y_com_out),         32'(m_yc));
    chk({tag, ".left"},    32'(bus.left_out),          32'(m_l));
    chk({tag, ".right"},   32'(bus.right_out),         32'(m_r));
    chk({tag, ".top"},     32'(bus.top_out),           32'(m_t));
    chk({tag, ".bot"},     32'(bus.bot_out),           32'(m_b));
    chk({tag, ".card"},    32'(bus.card_map_out),      32'(m_card));
    chk({tag, ".rank"},    32'(bus.rank_score_out),    32'(m_rs));
    chk({tag, ".suit"},    32'(bus.suit_score_out),    32'(m_ss));
    chk({tag, ".tcnt"},    32'(bus.timeout_count_out), 32'(m_tc));
    chk({tag, ".rcnt"},    32'(bus.reject_count_out),  32'(m_rc));
    chk({tag, ".state"},   32'(bus.state_out),         32'(m_state));
    chk({tag, ".cls_en"},  32'(bus.classify_en_out),   32'(m_ce));
  endtask

  // COM pulse, optionally colliding with frame_start; leaves the DUT one cycle into FIND_EDGES.
  task automatic do_com(input int x, input int y);
    bus.com_valid_in   = 1'b1;
    bus.frame_start_in = 1'($urandom_range(0, 1));
    bus.x_com_in       = 11'(x);
    bus.y_com_in       = 10'(y);
    step();
    idle_inputs();
    m_xc = x; m_yc = y; m_state = 1;
    chk("com.find_pulse", 32'(bus.find_corners_out), 32'd1);
    check_outs("com");
    step();
    chk("com.find_low", 32'(bus.find_corners_out), 32'd0);
  endtask

  task automatic do_edges(input int l, input int r, input int t, input int b);
    int n;
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      bus.frame_start_in = 1'($urandom_range(0, 1));
      bus.com_valid_in   = 1'($urandom_range(0, 1));
      bus.x_com_in       = 11'($urandom_range(0, 2047));
      step();
      idle_inputs();
      check_outs("find_noise");
    end
    bus.left_in = 11'(l); bus.right_in = 11'(r);
    bus.top_in  = 10'(t); bus.bot_in   = 10'(b);
    bus.edges_valid_in = 1'b1;
    step();
    idle_inputs();
    if (r >= l + 16 && b >= t + 16) begin
      m_l = l; m_r = r; m_t = t; m_b = b; m_state = 2;
    end else begin
      m_rc = (m_rc < 255) ? m_rc + 1 : 255;
      m_state = 0;
    end
    check_outs("edges");
  endtask

  // Timeout after 32 cycles in FIND_EDGES; with win, an accepted edge arrives on the timeout cycle.
  task automatic do_timeout(input bit win, input bit full);
    do_com($urandom_range(0, 2047), $urandom_range(0, 1023));
    repeat (30) step();
    if (full) check_outs("tmo_pre");
    if (win) begin
      bus.left_in = 11'd10; bus.right_in = 11'd26;
      bus.top_in  = 10'd20; bus.bot_in   = 10'd36;
      bus.edges_valid_in = 1'b1;
    end
    step();
    idle_inputs();
    if (win) begin
      m_l = 10; m_r = 26; m_t = 20; m_b = 36; m_state = 2;
    end else begin
      m_tc = (m_tc < 255) ? m_tc + 1 : 255;
      m_state = 0;
    end
    if (full) check_outs("tmo");
    else chk("tmo.state", 32'(bus.state_out), 32'(m_state));
  endtask

  task automatic do_classify(input int card, input int rs, input int ss);
    bit pub;
    bus.com_valid_in   = 1'b1;
    bus.edges_valid_in = 1'b1;
    step();
    idle_inputs();
    check_outs("arm_noise");
    bus.frame_start_in = 1'b1;
    step();
    idle_inputs();
    m_ce = 1; m_state = 3;
    check_outs("cls_open");
    for (int i = 0; i < 3; i++) begin
      bus.com_valid_in   = 1'($urandom_range(0, 1));
      bus.edges_valid_in = 1'($urandom_range(0, 1));
      bus.card_map_in    = 6'($urandom_range(0, 63));
      step();
      idle_inputs();
      check_outs("cls_noise");
    end
    bus.card_map_in    = 6'(card);
    bus.rank_score_in  = 7'(rs);
    bus.suit_score_in  = 7'(ss);
    bus.frame_start_in = 1'b1;
    step();
    idle_inputs();
`ifdef RESULT_HOLD_EN
    pub = (card == m_prev);
`else
    pub = 1'b1;
`endif
    m_prev = card;
    if (pub) begin
      m_card = card; m_rs = rs; m_ss = ss;
    end
    m_ce = 0; m_state = 0;
    chk("cls.result_valid", 32'(bus.result_valid_out), 32'(pub));
    check_outs("cls_done");
    step();
    chk("cls.result_low", 32'(bus.result_valid_out), 32'd0);
  endtask

  initial begin
    int l, t, cards[3];
    cards[0] = 'h12; cards[1] = 'h05; cards[2] = 'h21;
    idle_inputs();
    bus.x_com_in = '0; bus.y_com_in = '0;
    bus.left_in = '0; bus.right_in = '0; bus.top_in = '0; bus.bot_in = '0;
    bus.card_map_in = '0; bus.rank_score_in = '0; bus.suit_score_in = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    check_outs("reset");
    chk("reset.find", 32'(bus.find_corners_out), 32'd0);
    chk("reset.rv",   32'(bus.result_valid_out), 32'd0);

    do_com(200, 300);
    do_edges(100, 300, 150, 450);
    do_classify('h12, 40, 9);

    do_com(500, 400);
    do_edges(100, 110, 150, 450);
    do_com(501, 401);
    do_edges(2040, 2047, 0, 1023);

    do_timeout(1'b0, 1'b1);
    do_timeout(1'b1, 1'b1);
    do_classify('h12, 41, 10);
    do_com(7, 8);
    do_edges(0, 16, 0, 16);
    do_classify('h05, 77, 3);

    for (int k = 0; k < 40; k++) begin
      l = $urandom_range(0, 1000);
      t = $urandom_range(0, 500);
      do_com($urandom_range(0, 2047), $urandom_range(0, 1023));
      do_edges(l, l + $urandom_range(0, 40), t, t + $urandom_range(0, 40));
      if (m_state == 2)
        do_classify(cards[$urandom_range(0, 2)], $urandom_range(0, 127), $urandom_range(0, 127));
    end

    for (int k = 0; k < 300; k++) do_timeout(1'b0, k >= 295);
    chk("tcnt_sat", 32'(bus.timeout_count_out), 32'd255);

    do_com(33, 44);
    do_edges(100, 300, 150, 450);
    bus.frame_start_in = 1'b1;
    step();
    idle_inputs();
    m_ce = 1; m_state = 3;
    check_outs("pre_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_outs("mid_rst");
    chk("mid_rst.rv", 32'(bus.result_valid_out), 32'd0);
    bus.frame_start_in = 1'b1;
    bus.card_map_in    = 6'h2A;
    step();
    idle_inputs();
    chk("post_rst.rv", 32'(bus.result_valid_out), 32'd0);
    check_outs("post_rst");
    step();
    chk("post_rst.rv2", 32'(bus.result_valid_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
